aes_key_schedule_multi: RTL and testbench

Parametrised AES key-schedule engine supporting 128/192/256-bit keys, selected per key load at run time. Expands the cipher key into Nr+1 round keys (44/52/60 words), generating one 32-bit word per cycle. Serves the round datapath through a registered request/response round-key read port. Sits beside the AES-CTR core behind the AXI4-Lite register block, in the same slot as the current 128-bit-only schedule.

---
 rtl/aes_pkg.sv | 91 +++++++++
 rtl/aes_key_word_gen.sv | 52 +++++
 rtl/aes_key_schedule_multi.sv | 130 +++++++++++++
 tb/tb_aes_key_schedule_multi.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES shared definitions: key-length encoding, Nk/Nr/Nw lookups, round
// constants and the S-box (also used by the cipher datapath).
package aes_pkg;

    typedef enum logic [1:0] {
        KL_128 = 2'd0,
        KL_192 = 2'd1,
        KL_256 = 2'd2,
        KL_BAD = 2'd3
    } key_len_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [5:0] idx);
        case (idx)
            6'd1:    return 8'h01;
            6'd2:    return 8'h02;
            6'd3:    return 8'h04;
            6'd4:    return 8'h08;
            6'd5:    return 8'h10;
            6'd6:    return 8'h20;
            6'd7:    return 8'h40;
            6'd8:    return 8'h80;
            6'd9:    return 8'h1b;
            6'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [5:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 6'd6;
            KL_256:  return 6'd8;
            default: return 6'd4;
        endcase
    endfunction

    function automatic logic [5:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 6'd12;
            KL_256:  return 6'd14;
            default: return 6'd10;
        endcase
    endfunction

    function automatic logic [5:0] nw_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 6'd52;
            KL_256:  return 6'd60;
            default: return 6'd44;
        endcase
    endfunction

    function automatic int key_bits(input logic [1:0] kl);
        case (kl)
            KL_192:  return 192;
            KL_256:  return 256;
            default: return 128;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_word_gen.sv
// Combinational generator for one expanded key word.
// Ports:
//   w_prev - w[i-1]
//   w_nk   - w[i-Nk]
//   idx    - word index i being produced
//   mode   - key length code (0=128, 1=192, 2=256)
//   w_out  - w[i]
module aes_key_word_gen
    import aes_pkg::*;
(
    input  logic [31:0] w_prev,
    input  logic [31:0] w_nk,
    input  logic [5:0]  idx,
    input  logic [1:0]  mode,
    output logic [31:0] w_out
);

    logic [5:0]  quot;
    logic [5:0]  rem;
    logic [31:0] t;

    // Nk is a constant per mode, so the divisions reduce to shifts or a
    // small constant divider for AES-192.
    always_comb begin
        case (mode)
            KL_192: begin
                quot = idx / 6'd6;
                rem  = idx % 6'd6;
            end
            KL_256: begin
                quot = {3'b000, idx[5:3]};
                rem  = {3'b000, idx[2:0]};
            end
            default: begin
                quot = {2'b00, idx[5:2]};
                rem  = {4'b0000, idx[1:0]};
            end
        endcase
    end

    always_comb begin
        if (rem == 6'd0) begin
            t = sub_word(rot_word(w_prev)) ^ {rcon(quot), 24'h000000};
        end else if (mode == KL_256 && rem == 6'd4) begin
            t = sub_word(w_prev);
        end else begin
            t = w_prev;
        end
        w_out = w_nk ^ t;
    end

endmodule

// File: rtl/aes_key_schedule_multi.sv
// AES key-schedule engine for 128/192/256-bit keys, one word per clock,
// with a registered (latency-1) round-key read port.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start/key_len/key_in - load a key and begin expansion (key MSB-aligned)
//   busy/ready/cfg_err  - expansion running / schedule valid / start rejected
//   rk_req/rk_round     - round-key read request
//   rk_valid/rk_data/rk_err - read response (rk_err: bad round or not ready)
//   zeroize             - wipe request, honoured only when the macro
//                         KEY_SCHED_ZEROIZE_EN is defined
module aes_key_schedule_multi
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256,
    parameter int ROUND_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          key_len,
    input  logic [255:0]        key_in,
    output logic                busy,
    output logic                ready,
    output logic                cfg_err,
    input  logic                rk_req,
    input  logic [ROUND_W-1:0]  rk_round,
    output logic                rk_valid,
    output logic [127:0]        rk_data,
    output logic                rk_err,
    input  logic                zeroize
);

    localparam int NW_MAX = (MAX_KEY_BITS >= 256) ? 60 :
                            (MAX_KEY_BITS >= 192) ? 52 : 44;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GEN   = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [31:0] w [NW_MAX];
    logic [1:0]  state;
    logic [1:0]  mode;
    logic [5:0]  wi;
    logic [31:0] w_new;
    logic        start_ok;
    logic        rd_ok;
    logic [5:0]  rd_base;
    logic        zero_req;

`ifdef KEY_SCHED_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    logic unused_zeroize;
    assign unused_zeroize = zeroize;
    assign zero_req       = 1'b0;
`endif

    assign start_ok = start && (key_len != KL_BAD) && (key_bits(key_len) <= MAX_KEY_BITS);
    assign rd_ok    = ready && (int'(rk_round) <= int'(nr_of(mode)));
    assign rd_base  = 6'(rk_round) << 2;

    aes_key_word_gen u_word_gen (
        .w_prev (w[wi - 6'd1]),
        .w_nk   (w[wi - nk_of(mode)]),
        .idx    (wi),
        .mode   (mode),
        .w_out  (w_new)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            mode     <= 2'd0;
            wi       <= 6'd0;
            busy     <= 1'b0;
            ready    <= 1'b0;
            cfg_err  <= 1'b0;
            rk_valid <= 1'b0;
            rk_err   <= 1'b0;
            rk_data  <= '0;
            for (int k = 0; k < NW_MAX; k++) w[k] <= 32'h0;
        end else begin
            // Read port sees the schedule as it stood before this edge, so a
            // request alongside a start is answered from the old key.
            rk_valid <= rk_req;
            if (rk_req) begin
                if (rd_ok && !zero_req) begin
                    rk_data <= {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
                    rk_err  <= 1'b0;
                end else begin
                    rk_data <= '0;
                    rk_err  <= 1'b1;
                end
            end else begin
                rk_err <= 1'b0;
            end

            cfg_err <= start && !start_ok && !zero_req;

            if (zero_req) begin
                state <= ST_IDLE;
                mode  <= 2'd0;
                wi    <= 6'd0;
                busy  <= 1'b0;
                ready <= 1'b0;
                for (int k = 0; k < NW_MAX; k++) w[k] <= 32'h0;
            end else if (start_ok) begin
                // Restarting mid-expansion is allowed; the old run is discarded.
                for (int k = 0; k < 8; k++) begin
                    if (6'(k) < nk_of(key_len)) w[k] <= key_in[255 - 32*k -: 32];
                end
                mode  <= key_len;
                wi    <= nk_of(key_len);
                state <= ST_GEN;
                busy  <= 1'b1;
                ready <= 1'b0;
            end else if (state == ST_GEN) begin
                w[wi] <= w_new;
                if (wi == nw_of(mode) - 6'd1) begin
                    state <= ST_READY;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end else begin
                    wi <= wi + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_multi.sv
// Directed bench for aes_key_schedule_multi using FIPS-197 key expansion
// vectors for all three key sizes.
module tb_aes_key_schedule_multi;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         ready;
    logic         cfg_err;
    logic         rk_req;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic         rk_err;
    logic         zeroize;

    int n_chk = 0;
    int n_err = 0;
    int cnt;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_schedule_multi #(.MAX_KEY_BITS(256), .ROUND_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_len  (key_len),
        .key_in   (key_in),
        .busy     (busy),
        .ready    (ready),
        .cfg_err  (cfg_err),
        .rk_req   (rk_req),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .rk_data  (rk_data),
        .rk_err   (rk_err),
        .zeroize  (zeroize)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] kl, input logic [255:0] k);
        key_len = kl;
        key_in  = k;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic rd(input logic [3:0] r);
        rk_req   = 1'b1;
        rk_round = r;
        tick();
        rk_req   = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; key_len = 2'd0; key_in = '0;
        rk_req = 1'b0; rk_round = 4'd0; zeroize = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_ctrl", {busy, ready, cfg_err, rk_valid, rk_err}, 5'b00000);
        chk("reset_data", rk_data, 128'h0);

        // AES-128
        do_start(2'd0, K128);
        chk("busy_128", busy, 1'b1);
        wait_ready(cnt);
        chk("lat_128", cnt, 40);
        rd(4'd0);
        chk("r0_128_st", {rk_valid, rk_err}, 2'b10);
        chk("r0_128", rk_data, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd(4'd1);
        chk("r1_128", rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(4'd10);
        chk("r10_128_st", {rk_valid, rk_err}, 2'b10);
        chk("r10_128", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd(4'd11);
        chk("r11_128_st", {rk_valid, rk_err}, 2'b11);
        chk("r11_128", rk_data, 128'h0);

        // AES-192
        do_start(2'd1, K192);
        wait_ready(cnt);
        chk("lat_192", cnt, 46);
        rd(4'd1);
        chk("r1_192", rk_data, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        rd(4'd12);
        chk("r12_192_st", {rk_valid, rk_err}, 2'b10);
        chk("r12_192", rk_data, 128'he98ba06f448c773c8ecc720401002202);
        rd(4'd13);
        chk("r13_192_st", {rk_valid, rk_err}, 2'b11);

        // AES-256
        do_start(2'd2, K256);
        wait_ready(cnt);
        chk("lat_256", cnt, 52);
        rd(4'd1);
        chk("r1_256", rk_data, 128'h1f352c073b6108d72d9810a30914dff4);
        rd(4'd14);
        chk("r14_256", rk_data, 128'hfe4890d1e6188d0b046df344706c631e);
        rd(4'd15);
        chk("r15_256_st", {rk_valid, rk_err}, 2'b11);

        // Start with a simultaneous read answers from the old schedule,
        // then restart mid-GEN with AES-128.
        key_len = 2'd2; key_in = K256; start = 1'b1;
        rk_req = 1'b1; rk_round = 4'd14;
        tick();
        start = 1'b0; rk_req = 1'b0;
        chk("rd_at_start_st", {rk_valid, rk_err, busy, ready}, 4'b1010);
        chk("rd_at_start", rk_data, 128'hfe4890d1e6188d0b046df344706c631e);
        rd(4'd0);
        chk("rd_busy_st", {rk_valid, rk_err}, 2'b11);
        for (int k = 0; k < 7; k++) tick();
        do_start(2'd0, K128);
        wait_ready(cnt);
        chk("lat_restart", cnt, 40);
        rd(4'd10);
        chk("r10_restart", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Illegal key length while READY
        do_start(2'd3, K256);
        chk("cfg_err_pulse", {cfg_err, ready, busy}, 3'b110);
        tick();
        chk("cfg_err_clear", {cfg_err, ready}, 2'b01);
        rd(4'd10);
        chk("r10_after_bad", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        tick();
        chk("hold_valid", rk_valid, 1'b0);
        chk("hold_data", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reset in the middle of an expansion
        do_start(2'd1, K192);
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_gen_ctrl", {busy, ready, cfg_err, rk_valid, rk_err}, 5'b00000);
        chk("rst_gen_data", rk_data, 128'h0);
        rd(4'd0);
        chk("rd_after_rst", {rk_valid, rk_err}, 2'b11);

`ifdef KEY_SCHED_ZEROIZE_EN
        do_start(2'd0, K128);
        wait_ready(cnt);
        chk("lat_pre_zero", cnt, 40);
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("zero_ready", {ready, busy}, 2'b00);
        rd(4'd0);
        chk("zero_rd_st", {rk_valid, rk_err}, 2'b11);
        chk("zero_rd", rk_data, 128'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
